// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target endpoint.
package i2c_pkg;

   localparam int unsigned I2C_ADDR_W = 7;
   localparam int unsigned I2C_BYTE_W = 8;
   localparam logic        I2C_RW_READ = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_WR_DATA,
      S_WR_ACK,
      S_RD_DATA,
      S_RD_MACK,
      S_WAIT_STOP
   } i2c_slv_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Bus line input path: 2-flop synchronizer, optional glitch filter
// (I2C_SLAVE_GLITCH_FILTER_EN, FILT_LEN samples deep) and edge detect.
module i2c_line_sync
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
#(
   parameter int unsigned FILT_LEN = 4
)
`endif
(
   input  logic clk,
   input  logic arstn,
   input  logic line,
   output logic level,
   output logic rise,
   output logic fall
);

   // Idle bus level is high, so reset to 1 to avoid a spurious edge.
   logic [1:0] sync_q, sync_d;
   logic       prev_q, prev_d;
   logic       lvl;

   always_comb begin
      sync_d = {sync_q[0], line};
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         sync_q <= '1;
      end else begin
         sync_q <= sync_d;
      end
   end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
   logic [FILT_LEN-1:0] hist_q, hist_d;
   logic                filt_q, filt_d;

   // Output moves only once every sample in the window agrees.
   always_comb begin
      hist_d = {hist_q[FILT_LEN-2:0], sync_q[1]};
      filt_d = filt_q;
      if (&hist_q) begin
         filt_d = 1'b1;
      end else if (~|hist_q) begin
         filt_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         hist_q <= '1;
         filt_q <= 1'b1;
      end else begin
         hist_q <= hist_d;
         filt_q <= filt_d;
      end
   end

   always_comb begin
      lvl = filt_q;
   end
`else
   always_comb begin
      lvl = sync_q[1];
   end
`endif

   always_comb begin
      prev_d = lvl;
      level  = lvl;
      rise   = lvl & ~prev_q;
      fall   = ~lvl & prev_q;
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         prev_q <= 1'b1;
      end else begin
         prev_q <= prev_d;
      end
   end

endmodule

// File: rtl/i2c_slave.sv
// I2C target endpoint: fixed 7-bit address, byte-stream write/read, no stretching.
// Optional input glitch filter enabled by I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave
   import i2c_pkg::*;
#(
   parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'b1100101,
   parameter int unsigned           FILT_LEN   = 4
)
(
   input  logic                  clk,
   input  logic                  arstn,
   input  logic                  scl,
   inout  wire                   sda,
   input  logic [I2C_BYTE_W-1:0] data_send,
   output logic [I2C_BYTE_W-1:0] data_recv,
   output logic                  data_recv_done,
   output logic                  rd_load,
   output logic                  busy
);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;
   logic start_det, stop_det;

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
   i2c_line_sync #(.FILT_LEN(FILT_LEN)) u_scl_sync (
      .clk(clk), .arstn(arstn), .line(scl),
      .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
   );
   i2c_line_sync #(.FILT_LEN(FILT_LEN)) u_sda_sync (
      .clk(clk), .arstn(arstn), .line(sda),
      .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
   );
`else
   i2c_line_sync u_scl_sync (
      .clk(clk), .arstn(arstn), .line(scl),
      .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
   );
   i2c_line_sync u_sda_sync (
      .clk(clk), .arstn(arstn), .line(sda),
      .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
   );
`endif

   i2c_slv_state_t          state_q, state_d;
   logic [2:0]              bit_cnt_q, bit_cnt_d;
   logic [I2C_ADDR_W-1:0]   shift_q, shift_d;
   logic [I2C_BYTE_W-2:0]   tx_q, tx_d;
   logic                    sda_oe_q, sda_oe_d;
   logic                    rw_q, rw_d;
   logic [I2C_BYTE_W-1:0]   data_recv_q, data_recv_d;
   logic                    done_q, done_d;
   logic                    busy_q, busy_d;

   always_comb begin
      start_det = sda_fall & scl_lvl;
      stop_det  = sda_rise & scl_lvl;
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      tx_d        = tx_q;
      sda_oe_d    = sda_oe_q;
      rw_d        = rw_q;
      data_recv_d = data_recv_q;
      done_d      = 1'b0;
      busy_d      = busy_q;
      rd_load     = 1'b0;

      if (start_det) begin
         state_d   = S_ADDR;
         bit_cnt_d = '0;
         sda_oe_d  = 1'b0;
      end else if (stop_det) begin
         state_d   = S_IDLE;
         bit_cnt_d = '0;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE, S_WAIT_STOP: begin
               sda_oe_d = 1'b0;
            end
            S_ADDR: begin
               if (scl_rise) begin
                  shift_d   = {shift_q[I2C_ADDR_W-2:0], sda_lvl};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     if (shift_q == SLAVE_ADDR) begin
                        state_d = S_ADDR_ACK;
                        busy_d  = 1'b1;
                        rw_d    = sda_lvl;
                     end else begin
                        state_d = S_WAIT_STOP;
                        busy_d  = 1'b0;
                     end
                  end
               end
            end
            // ACK slots: first fall starts the drive, second fall ends the slot.
            S_ADDR_ACK: begin
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                  end else if (rw_q == I2C_RW_READ) begin
                     state_d   = S_RD_DATA;
                     tx_d      = data_send[I2C_BYTE_W-2:0];
                     sda_oe_d  = ~data_send[I2C_BYTE_W-1];
                     bit_cnt_d = '0;
                     rd_load   = 1'b1;
                  end else begin
                     state_d   = S_WR_DATA;
                     sda_oe_d  = 1'b0;
                     bit_cnt_d = '0;
                  end
               end
            end
            S_WR_DATA: begin
               if (scl_rise) begin
                  shift_d   = {shift_q[I2C_ADDR_W-2:0], sda_lvl};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     data_recv_d = {shift_q, sda_lvl};
                     done_d      = 1'b1;
                     state_d     = S_WR_ACK;
                  end
               end
            end
            S_WR_ACK: begin
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                  end else begin
                     state_d   = S_WR_DATA;
                     sda_oe_d  = 1'b0;
                     bit_cnt_d = '0;
                  end
               end
            end
            // Counter wraps to 0 on the 8th rise, so a fall with 0 ends the byte.
            S_RD_DATA: begin
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end else if (scl_fall) begin
                  if (bit_cnt_q == 3'd0) begin
                     state_d  = S_RD_MACK;
                     sda_oe_d = 1'b0;
                  end else begin
                     tx_d     = {tx_q[I2C_BYTE_W-3:0], 1'b0};
                     sda_oe_d = ~tx_q[I2C_BYTE_W-2];
                  end
               end
            end
            S_RD_MACK: begin
               if (scl_rise) begin
                  if (sda_lvl) begin
                     state_d = S_WAIT_STOP;
                  end
               end else if (scl_fall) begin
                  state_d   = S_RD_DATA;
                  tx_d      = data_send[I2C_BYTE_W-2:0];
                  sda_oe_d  = ~data_send[I2C_BYTE_W-1];
                  bit_cnt_d = '0;
                  rd_load   = 1'b1;
               end
            end
            default: begin
               state_d  = S_IDLE;
               sda_oe_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state_q     <= S_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         tx_q        <= '0;
         sda_oe_q    <= 1'b0;
         rw_q        <= 1'b0;
         data_recv_q <= '0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         tx_q        <= tx_d;
         sda_oe_q    <= sda_oe_d;
         rw_q        <= rw_d;
         data_recv_q <= data_recv_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
      end
   end

   assign sda            = sda_oe_q ? 1'b0 : 1'bz;
   assign data_recv      = data_recv_q;
   assign data_recv_done = done_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench for i2c_slave: bit-banged controller with a byte-level reference model.
module tb_i2c_slave;

   localparam int Q = 10;

   logic       clk = 1'b0;
   logic       arstn = 1'b0;
   logic       scl = 1'b1;
   logic       sda_m = 1'b1;
   logic [7:0] data_send = 8'h00;
   logic [7:0] data_recv;
   logic       data_recv_done;
   logic       rd_load;
   logic       busy;
   wire        sda_w;

   assign sda_w = sda_m ? 1'bz : 1'b0;
   pullup (sda_w);

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int load_cnt = 0;
   int drv_cnt = 0;

   always #5 clk = ~clk;

   i2c_slave #(.SLAVE_ADDR(7'h65), .FILT_LEN(4)) dut (
      .clk(clk), .arstn(arstn), .scl(scl), .sda(sda_w),
      .data_send(data_send), .data_recv(data_recv),
      .data_recv_done(data_recv_done), .rd_load(rd_load), .busy(busy)
   );

   always @(negedge clk) begin
      if (data_recv_done) done_cnt++;
      if (rd_load) load_cnt++;
      if (sda_m && sda_w === 1'b0) drv_cnt++;
   end

   task automatic wclk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic m_start;
      sda_m = 1'b1; scl = 1'b1; wclk(Q);
      sda_m = 1'b0; wclk(Q);
      scl = 1'b0;
   endtask

   task automatic m_rstart;
      wclk(Q); sda_m = 1'b1;
      wclk(Q); scl = 1'b1;
      wclk(Q); sda_m = 1'b0;
      wclk(Q); scl = 1'b0;
   endtask

   task automatic m_stop;
      wclk(Q); sda_m = 1'b0;
      wclk(Q); scl = 1'b1;
      wclk(Q); sda_m = 1'b1;
      wclk(2*Q);
   endtask

   task automatic m_wbit(input logic b);
      wclk(Q); sda_m = b;
      wclk(Q); scl = 1'b1;
      wclk(2*Q); scl = 1'b0;
   endtask

   task automatic m_wbit_glitch(input logic b);
      wclk(Q); sda_m = b;
      wclk(3); scl = 1'b1;
      wclk(2); scl = 1'b0;
      wclk(Q-5); scl = 1'b1;
      wclk(2*Q); scl = 1'b0;
   endtask

   task automatic m_rbit(output logic b);
      wclk(Q); sda_m = 1'b1;
      wclk(Q); scl = 1'b1;
      wclk(Q); b = sda_w;
      wclk(Q); scl = 1'b0;
   endtask

   task automatic m_wbyte(input logic [7:0] b, output logic ack);
      logic a;
      for (int i = 7; i >= 0; i--) m_wbit(b[i]);
      m_rbit(a);
      ack = ~a;
   endtask

   task automatic m_rbyte(output logic [7:0] d);
      logic v;
      for (int i = 7; i >= 0; i--) begin
         m_rbit(v);
         d[i] = v;
      end
   endtask

   task automatic test_reset;
      arstn = 1'b0;
      wclk(4);
      checks++; if (data_recv !== 8'h00) begin errors++; $display("FAIL rst_data_recv got %0h want 00", data_recv); end
      checks++; if (data_recv_done !== 1'b0) begin errors++; $display("FAIL rst_done got %0b want 0", data_recv_done); end
      checks++; if (rd_load !== 1'b0) begin errors++; $display("FAIL rst_rd_load got %0b want 0", rd_load); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", busy); end
      checks++; if (sda_w !== 1'b1) begin errors++; $display("FAIL rst_sda got %0b want 1 (released)", sda_w); end
      arstn = 1'b1;
      wclk(4);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy_after got %0b want 0", busy); end
   endtask

   task automatic test_write;
      logic ack;
      logic [7:0] b;
      int d0;
      for (int t = 0; t < 4; t++) begin
         b = (t == 0) ? 8'h63 : 8'($urandom);
         d0 = done_cnt;
         m_start;
         m_wbyte({7'h65, 1'b0}, ack);
         checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wr_addr_ack got %0b want 1", ack); end
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy got %0b want 1", busy); end
         m_wbyte(b, ack);
         checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wr_data_ack got %0b want 1", ack); end
         checks++; if (data_recv !== b) begin errors++; $display("FAIL wr_data got %0h want %0h", data_recv, b); end
         m_stop;
         checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL wr_done_cnt got %0d want 1", done_cnt - d0); end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_stop got %0b want 0", busy); end
      end
   endtask

   task automatic test_read;
      logic ack;
      logic [7:0] exp_b, got;
      int l0, nb;
      for (int t = 0; t < 4; t++) begin
         nb = (t == 0) ? 1 : 2;
         exp_b = (t == 0) ? 8'hE3 : 8'($urandom);
         data_send = exp_b;
         l0 = load_cnt;
         m_start;
         m_wbyte({7'h65, 1'b1}, ack);
         checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rd_addr_ack got %0b want 1", ack); end
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rd_busy got %0b want 1", busy); end
         for (int k = 0; k < nb; k++) begin
            m_rbyte(got);
            checks++; if (got !== exp_b) begin errors++; $display("FAIL rd_data byte %0d got %0h want %0h", k, got, exp_b); end
            if (k == nb - 1) begin
               m_wbit(1'b1);
            end else begin
               exp_b = 8'($urandom);
               data_send = exp_b;
               m_wbit(1'b0);
            end
         end
         wclk(4);
         checks++; if (sda_w !== 1'b1) begin errors++; $display("FAIL rd_release got %0b want 1", sda_w); end
         checks++; if (load_cnt - l0 != nb) begin errors++; $display("FAIL rd_load_cnt got %0d want %0d", load_cnt - l0, nb); end
         m_stop;
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy_stop got %0b want 0", busy); end
      end
   endtask

   task automatic test_mismatch;
      logic ack;
      logic [6:0] a;
      int d0, v0;
      for (int t = 0; t < 3; t++) begin
         a = (t == 0) ? 7'h23 : 7'($urandom);
         if (a == 7'h65) a = 7'h64;
         d0 = done_cnt;
         v0 = drv_cnt;
         m_start;
         m_wbyte({a, 1'($urandom)}, ack);
         checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mm_addr_ack addr %0h got %0b want 0", a, ack); end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mm_busy got %0b want 0", busy); end
         m_wbyte(8'($urandom), ack);
         m_stop;
         checks++; if (drv_cnt - v0 != 0) begin errors++; $display("FAIL mm_sda_driven got %0d clk want 0", drv_cnt - v0); end
         checks++; if (done_cnt - d0 != 0) begin errors++; $display("FAIL mm_done got %0d want 0", done_cnt - d0); end
      end
   endtask

   task automatic test_back_to_back;
      logic ack;
      logic [7:0] got, exp_b;
      int d0;
      d0 = done_cnt;
      m_start;
      m_wbyte({7'h65, 1'b0}, ack);
      m_wbyte(8'h12, ack);
      checks++; if (data_recv !== 8'h12) begin errors++; $display("FAIL b2b_first got %0h want 12", data_recv); end
      m_wbyte(8'h34, ack);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL b2b_ack got %0b want 1", ack); end
      m_stop;
      checks++; if (done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_done_cnt got %0d want 2", done_cnt - d0); end
      checks++; if (data_recv !== 8'h34) begin errors++; $display("FAIL b2b_last got %0h want 34", data_recv); end

      exp_b = 8'($urandom);
      data_send = exp_b;
      m_start;
      m_wbyte({7'h65, 1'b0}, ack);
      for (int i = 0; i < 3; i++) m_wbit(1'($urandom));
      m_rstart;
      m_wbyte({7'h65, 1'b1}, ack);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rstart_ack got %0b want 1", ack); end
      m_rbyte(got);
      checks++; if (got !== exp_b) begin errors++; $display("FAIL rstart_data got %0h want %0h", got, exp_b); end
      m_wbit(1'b1);
      m_stop;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstart_busy got %0b want 0", busy); end
   endtask

   task automatic test_async_reset;
      logic ack;
      data_send = 8'($urandom) & 8'h7F;
      m_start;
      m_wbyte({7'h65, 1'b1}, ack);
      wclk(5);
      checks++; if (sda_w !== 1'b0) begin errors++; $display("FAIL arst_pre_drive got %0b want 0", sda_w); end
      #2;
      arstn = 1'b0;
      #1;
      checks++; if (sda_w !== 1'b1) begin errors++; $display("FAIL arst_sda got %0b want 1", sda_w); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %0b want 0", busy); end
      checks++; if (data_recv !== 8'h00) begin errors++; $display("FAIL arst_data_recv got %0h want 00", data_recv); end
      checks++; if (data_recv_done !== 1'b0 || rd_load !== 1'b0) begin errors++; $display("FAIL arst_pulses got %0b%0b want 00", data_recv_done, rd_load); end
      scl = 1'b1;
      wclk(Q);
      arstn = 1'b1;
      wclk(Q);
   endtask

   task automatic test_glitch;
      logic ack;
      logic [7:0] b, exp_b;
      logic q[$];
      int gi, d0;
      for (int t = 0; t < 2; t++) begin
         b = 8'hA5;
         gi = $urandom_range(7, 1);
         q.delete();
         for (int i = 7; i >= 0; i--) begin
            if (i == gi) q.push_back(b[i]);
            q.push_back(b[i]);
         end
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
         exp_b = b;
`else
         for (int i = 0; i < 8; i++) exp_b[7-i] = q[i];
`endif
         d0 = done_cnt;
         m_start;
         m_wbyte({7'h65, 1'b0}, ack);
         for (int i = 7; i >= 0; i--) begin
            if (i == gi) m_wbit_glitch(b[i]);
            else m_wbit(b[i]);
         end
         m_rbit(ack);
         m_stop;
         checks++; if (data_recv !== exp_b) begin errors++; $display("FAIL glitch_data bit %0d got %0h want %0h", gi, data_recv, exp_b); end
         checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL glitch_done got %0d want 1", done_cnt - d0); end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      test_reset;
      test_write;
      test_read;
      test_mismatch;
      test_back_to_back;
      test_async_reset;
      test_glitch;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
